// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic light controller: phase encoding,
// interval select codes, one-hot light codes and default intervals.
package traffic_pkg;

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_MG1    = 3'd1,
    S_MG2    = 3'd2,
    S_MY     = 3'd3,
    S_WALK   = 3'd4,
    S_SG     = 3'd5,
    S_SG_EXT = 3'd6,
    S_SY     = 3'd7
  } state_t;

  localparam logic [1:0] PARAM_BASE = 2'b00;
  localparam logic [1:0] PARAM_EXT  = 2'b01;
  localparam logic [1:0] PARAM_YEL  = 2'b10;

  localparam logic [2:0] LT_RED = 3'b100;
  localparam logic [2:0] LT_YEL = 3'b010;
  localparam logic [2:0] LT_GRN = 3'b001;

  localparam logic [3:0] T_BASE_DEFAULT = 4'd6;
  localparam logic [3:0] T_EXT_DEFAULT  = 4'd3;
  localparam logic [3:0] T_YEL_DEFAULT  = 4'd2;

  // Debug view of the controller's internal state.
  typedef struct packed {
    state_t state;
    logic   walk_latch;
    logic   walk_again;
    logic   guard;
  } dbg_t;

  function automatic logic [2:0] main_light(state_t s);
    case (s)
      S_MG1, S_MG2: main_light = LT_GRN;
      S_MY:         main_light = LT_YEL;
      default:      main_light = LT_RED;
    endcase
  endfunction

  function automatic logic [2:0] side_light(state_t s);
    case (s)
      S_SG, S_SG_EXT: side_light = LT_GRN;
      S_SY:           side_light = LT_YEL;
      default:        side_light = LT_RED;
    endcase
  endfunction

endpackage

// File: rtl/time_param_regs.sv
// Programmable base / extended / yellow interval registers with write decode,
// zero clamp, and a per-phase interval lookup.
module time_param_regs
  import traffic_pkg::*;
#(
  parameter logic [3:0] T_BASE_DEF = T_BASE_DEFAULT,
  parameter logic [3:0] T_EXT_DEF  = T_EXT_DEFAULT,
  parameter logic [3:0] T_YEL_DEF  = T_YEL_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       prog_sync,
  input  logic [1:0] time_param_sel,
  input  logic [3:0] time_value,
  input  state_t     phase,
  output logic [3:0] interval
);

  logic [3:0] t_base, t_ext, t_yel;
  logic [3:0] t_base_nxt, t_ext_nxt, t_yel_nxt;
  logic [3:0] wr_value;

  always_comb begin
    wr_value   = (time_value == 4'd0) ? 4'd1 : time_value;
    t_base_nxt = t_base;
    t_ext_nxt  = t_ext;
    t_yel_nxt  = t_yel;
    if (prog_sync) begin
      case (time_param_sel)
        PARAM_BASE: t_base_nxt = wr_value;
        PARAM_EXT:  t_ext_nxt  = wr_value;
        PARAM_YEL:  t_yel_nxt  = wr_value;
        default:    ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      t_base <= T_BASE_DEF;
      t_ext  <= T_EXT_DEF;
      t_yel  <= T_YEL_DEF;
    end else begin
      t_base <= t_base_nxt;
      t_ext  <= t_ext_nxt;
      t_yel  <= t_yel_nxt;
    end
  end

  // Lookup uses post-write values so the restart after a write carries the new interval.
  always_comb begin
    case (phase)
      S_MG1, S_MG2, S_SG: interval = t_base_nxt;
      S_MY, S_SY:         interval = t_yel_nxt;
      S_WALK, S_SG_EXT:   interval = t_ext_nxt;
      default:            interval = 4'd0;
    endcase
  end

endmodule

// File: rtl/traffic_controller.sv
// Main traffic light FSM: sequences the phases, latches walk requests and
// issues one start pulse with the phase interval to the shared Timer.
module traffic_controller
  import traffic_pkg::*;
#(
  parameter logic [3:0] T_BASE_DEF = T_BASE_DEFAULT,
  parameter logic [3:0] T_EXT_DEF  = T_EXT_DEFAULT,
  parameter logic [3:0] T_YEL_DEF  = T_YEL_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sensor,
  input  logic       walk_request,
  input  logic       prog_sync,
  input  logic [1:0] time_param_sel,
  input  logic [3:0] time_value,
  input  logic       expired,
  output logic       start_timer,
  output logic [3:0] parm_value,
  output logic [2:0] main_lights,
  output logic [2:0] side_lights,
  output logic       walk,
  output dbg_t       dbg
);

  state_t     state, next_state;
  logic       enter;
  logic       exp_ok;
  logic       guard;
  logic       walk_latch, walk_again;
  logic       walk_exit;
  logic [3:0] next_interval;

  time_param_regs #(
    .T_BASE_DEF (T_BASE_DEF),
    .T_EXT_DEF  (T_EXT_DEF),
    .T_YEL_DEF  (T_YEL_DEF)
  ) u_time_param_regs (
    .clk            (clk),
    .reset          (reset),
    .prog_sync      (prog_sync),
    .time_param_sel (time_param_sel),
    .time_value     (time_value),
    .phase          (next_state),
    .interval       (next_interval)
  );

  // The Timer still shows the old expiry during the start cycle and the one after.
  assign exp_ok = expired && !start_timer && !guard;

  always_comb begin
    next_state = state;
    enter      = 1'b0;
    if (prog_sync || state == S_INIT) begin
      next_state = S_MG1;
      enter      = 1'b1;
    end else if (exp_ok) begin
      enter = 1'b1;
      case (state)
        S_MG1:    next_state = sensor ? S_MY : S_MG2;
        S_MG2:    next_state = S_MY;
        S_MY:     next_state = walk_latch ? S_WALK : S_SG;
        S_WALK:   next_state = S_SG;
        S_SG:     next_state = sensor ? S_SG_EXT : S_SY;
        S_SG_EXT: next_state = S_SY;
        S_SY:     next_state = S_MG1;
        default:  next_state = S_INIT;
      endcase
    end
  end

  assign walk_exit = (state == S_WALK) && enter;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_INIT;
      start_timer <= 1'b0;
      parm_value  <= 4'd0;
      main_lights <= LT_RED;
      side_lights <= LT_RED;
      walk        <= 1'b0;
      guard       <= 1'b0;
      walk_latch  <= 1'b0;
      walk_again  <= 1'b0;
    end else begin
      state       <= next_state;
      start_timer <= enter;
      parm_value  <= enter ? next_interval : 4'd0;
      main_lights <= main_light(next_state);
      side_lights <= side_light(next_state);
      walk        <= (next_state == S_WALK);
      guard       <= start_timer;
      // A request seen while walking is held aside and becomes the latch on exit.
      if (walk_exit) begin
        walk_latch <= walk_again | walk_request;
        walk_again <= 1'b0;
      end else if (state == S_WALK) begin
        if (walk_request) walk_again <= 1'b1;
      end else if (walk_request) begin
        walk_latch <= 1'b1;
      end
    end
  end

  assign dbg = {state, walk_latch, walk_again, guard};

endmodule

// File: tb/tb_traffic_controller.sv
// Directed plus randomized bench for traffic_controller; the bench plays the
// Timer and tracks the expected phase with a string-level reference model.
module tb_traffic_controller;
  import traffic_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       sensor;
  logic       walk_request;
  logic       prog_sync;
  logic [1:0] time_param_sel;
  logic [3:0] time_value;
  logic       expired;
  logic       start_timer;
  logic [3:0] parm_value;
  logic [2:0] main_lights;
  logic [2:0] side_lights;
  logic       walk;
  dbg_t       dbg;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  string      cur;
  logic [7:0] t_base, t_ext, t_yel;
  bit         walk_flag;
  logic [7:0] exp_q[$];

  traffic_controller dut (
    .clk            (clk),
    .reset          (reset),
    .sensor         (sensor),
    .walk_request   (walk_request),
    .prog_sync      (prog_sync),
    .time_param_sel (time_param_sel),
    .time_value     (time_value),
    .expired        (expired),
    .start_timer    (start_timer),
    .parm_value     (parm_value),
    .main_lights    (main_lights),
    .side_lights    (side_lights),
    .walk           (walk),
    .dbg            (dbg)
  );

  // Clock and reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout reached before end of stimulus");
    $fatal(1, "timeout");
  end

  // Model rules
  function automatic logic [7:0] interval_of(string ph);
    if (ph == "MY" || ph == "SY") return t_yel;
    if (ph == "WALK" || ph == "SGX") return t_ext;
    return t_base;
  endfunction

  function automatic logic [2:0] main_of(string ph);
    if (ph == "MG1" || ph == "MG2") return 3'b001;
    if (ph == "MY") return 3'b010;
    return 3'b100;
  endfunction

  function automatic logic [2:0] side_of(string ph);
    if (ph == "SG" || ph == "SGX") return 3'b001;
    if (ph == "SY") return 3'b010;
    return 3'b100;
  endfunction

  function automatic string next_of(string ph, bit s);
    if (ph == "MG1") return s ? "MY" : "MG2";
    if (ph == "MG2") return "MY";
    if (ph == "MY") return walk_flag ? "WALK" : "SG";
    if (ph == "WALK") return "SG";
    if (ph == "SG") return s ? "SGX" : "SY";
    if (ph == "SGX") return "SY";
    return "MG1";
  endfunction

  // Driver and checker tasks
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h phase=%s", tag, obs, expv, cur);
    end
  endtask

  task automatic enter(string ph);
    cur = ph;
    if (ph == "WALK") walk_flag = 1'b0;
    exp_q.push_back(interval_of(ph));
  endtask

  task automatic check_entry(string tag);
    logic [7:0] e;
    e = exp_q.pop_front();
    chk({tag, "_start"}, {7'd0, start_timer}, 8'd1);
    chk({tag, "_parm"}, {4'd0, parm_value}, e);
    chk({tag, "_main"}, {5'd0, main_lights}, {5'd0, main_of(cur)});
    chk({tag, "_side"}, {5'd0, side_lights}, {5'd0, side_of(cur)});
    chk({tag, "_walk"}, {7'd0, walk}, (cur == "WALK") ? 8'd1 : 8'd0);
  endtask

  task automatic check_hold(string tag);
    chk({tag, "_start"}, {7'd0, start_timer}, 8'd0);
    chk({tag, "_main"}, {5'd0, main_lights}, {5'd0, main_of(cur)});
    chk({tag, "_side"}, {5'd0, side_lights}, {5'd0, side_of(cur)});
    chk({tag, "_walk"}, {7'd0, walk}, (cur == "WALK") ? 8'd1 : 8'd0);
  endtask

  task automatic check_reset_values(string tag);
    chk({tag, "_start"}, {7'd0, start_timer}, 8'd0);
    chk({tag, "_parm"}, {4'd0, parm_value}, 8'd0);
    chk({tag, "_main"}, {5'd0, main_lights}, 8'b100);
    chk({tag, "_side"}, {5'd0, side_lights}, 8'b100);
    chk({tag, "_walk"}, {7'd0, walk}, 8'd0);
    chk({tag, "_dbg"}, {2'd0, dbg}, {2'd0, S_INIT, 3'b000});
  endtask

  // Called in the start cycle of a phase; ends in the start cycle of the next one.
  task automatic do_phase(bit s, bit wreq);
    int n;
    tick;
    sensor = 1'($urandom_range(0, 1));
    if (wreq) begin
      walk_request = 1'b1;
      walk_flag    = 1'b1;
    end
    check_hold({cur, "_ign0"});
    tick;
    walk_request = 1'b0;
    check_hold({cur, "_ign1"});
    expired = 1'b0;
    n = int'($urandom_range(0, 3));
    for (int i = 0; i < n; i++) begin
      sensor = 1'($urandom_range(0, 1));
      tick;
      check_hold({cur, "_wait"});
    end
    sensor  = s;
    expired = 1'b1;
    tick;
    enter(next_of(cur, s));
    check_entry(cur);
  endtask

  task automatic do_prog(logic [1:0] sel, logic [3:0] val, bit exp_too);
    logic [7:0] v;
    tick;
    check_hold({cur, "_preprog"});
    prog_sync      = 1'b1;
    time_param_sel = sel;
    time_value     = val;
    sensor         = 1'($urandom_range(0, 1));
    if (exp_too) expired = 1'b1;
    tick;
    prog_sync = 1'b0;
    v = (val == 4'd0) ? 8'd1 : {4'd0, val};
    if (sel == 2'd0) t_base = v;
    else if (sel == 2'd1) t_ext = v;
    else if (sel == 2'd2) t_yel = v;
    enter("MG1");
    check_entry("prog_MG1");
  endtask

  initial begin
    reset          = 1'b0;
    sensor         = 1'b0;
    walk_request   = 1'b0;
    prog_sync      = 1'b0;
    time_param_sel = 2'd0;
    time_value     = 4'd0;
    expired        = 1'b0;
    t_base         = 8'd6;
    t_ext          = 8'd3;
    t_yel          = 8'd2;
    walk_flag      = 1'b0;
    cur            = "INIT";

    // Reset state
    repeat (2) tick;
    check_reset_values("reset");
    reset = 1'b1;
    tick;
    enter("MG1");
    check_entry("first_MG1");

    // Default loop: MG1, MG2, MY, SG, SY, MG1
    repeat (5) do_phase(1'b0, 1'b0);

    // Sensor: skip MG2, extend side green
    do_phase(1'b1, 1'b0);
    do_phase(1'b0, 1'b0);
    do_phase(1'b1, 1'b0);
    do_phase(1'b0, 1'b0);
    do_phase(1'b0, 1'b0);

    // Walk request in MG2, second request during WALK, then latch clear
    do_phase(1'b0, 1'b0);
    do_phase(1'b0, 1'b1);
    do_phase(1'b0, 1'b0);
    do_phase(1'b0, 1'b1);
    repeat (2) do_phase(1'b0, 1'b0);
    do_phase(1'b1, 1'b0);
    repeat (4) do_phase(1'b0, 1'b0);
    do_phase(1'b1, 1'b0);
    do_phase(1'b0, 1'b0);

    // Programming: base=4 with simultaneous expiry in SG, yellow=0, reserved select
    do_prog(2'b00, 4'd4, 1'b1);
    do_prog(2'b10, 4'd0, 1'b0);
    do_phase(1'b1, 1'b0);
    do_prog(2'b11, 4'd9, 1'b0);
    do_phase(1'b1, 1'b0);
    do_phase(1'b0, 1'b0);
    do_phase(1'b1, 1'b0);
    repeat (2) do_phase(1'b0, 1'b0);

    // Randomized phases with occasional reprogramming
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 7) == 0 && cur != "WALK")
        do_prog(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      else
        do_phase(1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
    end

    // Reset asserted mid-SY
    for (int k = 0; k < 20 && cur != "SY"; k++) do_phase(1'($urandom_range(0, 1)), 1'b0);
    tick;
    #3 reset = 1'b0;
    #1;
    cur = "INIT";
    check_reset_values("async_reset");
    tick;
    check_reset_values("held_reset");
    expired   = 1'b0;
    t_base    = 8'd6;
    t_ext     = 8'd3;
    t_yel     = 8'd2;
    walk_flag = 1'b0;
    reset     = 1'b1;
    tick;
    enter("MG1");
    check_entry("post_reset_MG1");
    do_phase(1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
